// File: rtl/sonar_pkg.sv
// rtl/sonar_pkg.sv - shared types and helpers for the sonar ranging front end
package sonar_pkg;

    localparam int DIST_W = 13;

    typedef logic [DIST_W-1:0] dist_t;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        DONE
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sonar_avg4.sv
// rtl/sonar_avg4.sv - 4-sample moving average of distance, preloaded by the first sample
module sonar_avg4
    import sonar_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  in_valid,
    input  dist_t in_dist,
    input  logic  in_timeout,
    output logic  out_valid,
    output dist_t out_dist,
    output logic  out_timeout
);

    dist_t       hist_q [4];
    dist_t       hist_d [4];
    logic [14:0] sum_q, sum_d;
    logic        primed_q, primed_d;
    logic        valid_q, valid_d;
    logic        to_q, to_d;

    always_comb begin
        hist_d   = hist_q;
        sum_d    = sum_q;
        primed_d = primed_q;
        valid_d  = in_valid;
        to_d     = to_q;
        if (in_valid) begin
            to_d = in_timeout;
            if (!primed_q) begin
                // First sample fills the whole window so the average starts at that value
                for (int i = 0; i < 4; i++) hist_d[i] = in_dist;
                sum_d    = 15'(in_dist) << 2;
                primed_d = 1'b1;
            end else begin
                hist_d[0] = in_dist;
                for (int i = 1; i < 4; i++) hist_d[i] = hist_q[i-1];
                sum_d = sum_q + 15'(in_dist) - 15'(hist_q[3]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) hist_q[i] <= '0;
            sum_q    <= '0;
            primed_q <= 1'b0;
            valid_q  <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            hist_q   <= hist_d;
            sum_q    <= sum_d;
            primed_q <= primed_d;
            valid_q  <= valid_d;
            to_q     <= to_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_dist    = sum_q[14:2];
    assign out_timeout = to_q;

endmodule

// File: rtl/sonar_distance.sv
// rtl/sonar_distance.sv - HC-SR04 style trigger/echo ranging to mm; SONAR_DIST_AVG_EN adds 4-sample averaging
module sonar_distance
    import sonar_pkg::*;
#(
    parameter int CYCLES_PER_MM       = 292,
    parameter int TRIG_CYCLES         = 500,
    parameter int HOLDOFF_CYCLES      = 3000000,
    parameter int ECHO_TIMEOUT_CYCLES = 1500000,
    parameter int MAX_MM              = 4000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              echo,
    output logic              trig,
    output logic [DIST_W-1:0] distance,
    output logic              dist_valid,
    output logic              timeout_err
);

    localparam int CNT_MAX = max3(TRIG_CYCLES, HOLDOFF_CYCLES, ECHO_TIMEOUT_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PRE_W   = (CYCLES_PER_MM > 1) ? $clog2(CYCLES_PER_MM) : 1;

    logic             sync1_q, echo_s_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    dist_t            mm_q, mm_d;
    logic             to_flag_q, to_flag_d;
    logic             trig_q, trig_d;
    dist_t            raw_dist_q, raw_dist_d;
    logic             raw_valid_q, raw_valid_d;
    logic             raw_to_q, raw_to_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        presc_d     = presc_q;
        mm_d        = mm_q;
        to_flag_d   = to_flag_q;
        raw_dist_d  = raw_dist_q;
        raw_to_d    = raw_to_q;
        raw_valid_d = 1'b0;
        trig_d      = (state_q == TRIG);
        case (state_q)
            IDLE: begin
                // Holdoff expires, then wait for any saturated echo tail to end
                if (cnt_q == CNT_W'(HOLDOFF_CYCLES - 1)) begin
                    if (!echo_s_q) begin
                        state_d = TRIG;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TRIG: begin
                if (cnt_q == CNT_W'(TRIG_CYCLES - 1)) begin
                    state_d = WAIT_ECHO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_ECHO: begin
                if (echo_s_q) begin
                    state_d = MEASURE;
                    presc_d = PRE_W'(1);
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(ECHO_TIMEOUT_CYCLES - 1)) begin
                    state_d   = DONE;
                    mm_d      = dist_t'(MAX_MM);
                    to_flag_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MEASURE: begin
                if (!echo_s_q) begin
                    state_d = DONE;
                end else if (presc_q == PRE_W'(CYCLES_PER_MM - 1)) begin
                    presc_d = '0;
                    mm_d    = mm_q + 1'b1;
                    if (mm_q == dist_t'(MAX_MM - 1)) state_d = DONE;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            DONE: begin
                raw_dist_d  = mm_q;
                raw_to_d    = to_flag_q;
                raw_valid_d = 1'b1;
                mm_d        = '0;
                presc_d     = '0;
                to_flag_d   = 1'b0;
                cnt_d       = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            echo_s_q    <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            presc_q     <= '0;
            mm_q        <= '0;
            to_flag_q   <= 1'b0;
            trig_q      <= 1'b0;
            raw_dist_q  <= '0;
            raw_valid_q <= 1'b0;
            raw_to_q    <= 1'b0;
        end else begin
            sync1_q     <= echo;
            echo_s_q    <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            presc_q     <= presc_d;
            mm_q        <= mm_d;
            to_flag_q   <= to_flag_d;
            trig_q      <= trig_d;
            raw_dist_q  <= raw_dist_d;
            raw_valid_q <= raw_valid_d;
            raw_to_q    <= raw_to_d;
        end
    end

    assign trig = trig_q;

`ifdef SONAR_DIST_AVG_EN
    sonar_avg4 u_avg (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (raw_valid_q),
        .in_dist     (raw_dist_q),
        .in_timeout  (raw_to_q),
        .out_valid   (dist_valid),
        .out_dist    (distance),
        .out_timeout (timeout_err)
    );
`else
    assign distance    = raw_dist_q;
    assign dist_valid  = raw_valid_q;
    assign timeout_err = raw_to_q;
`endif

endmodule

// File: tb/tb_sonar_distance.sv
// tb/tb_sonar_distance.sv - self-checking bench for sonar_distance with small parameters
module tb_sonar_distance;

    localparam int CPM   = 4;
    localparam int TRG   = 5;
    localparam int HOLD  = 20;
    localparam int TOUT  = 100;
    localparam int MAXMM = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic        echo;
    logic        trig;
    logic [12:0] distance;
    logic        dist_valid;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    int hist[$];

    typedef struct {
        int len;
        int exp_d;
        int exp_t;
    } vec_t;

    vec_t vecs[9];

    sonar_distance #(
        .CYCLES_PER_MM       (CPM),
        .TRIG_CYCLES         (TRG),
        .HOLDOFF_CYCLES      (HOLD),
        .ECHO_TIMEOUT_CYCLES (TOUT),
        .MAX_MM              (MAXMM)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .echo        (echo),
        .trig        (trig),
        .distance    (distance),
        .dist_valid  (dist_valid),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bounded wait expired", name);
    endtask

    // Reference: one echo of len cycles gives floor(len/CPM) mm, capped; no echo is a timeout
    task automatic expect_for(input int len, output int d, output int t);
        int s;
        if (len == 0) begin
            d = MAXMM;
            t = 1;
        end else begin
            d = len / CPM;
            if (d > MAXMM) d = MAXMM;
            t = 0;
        end
`ifdef SONAR_DIST_AVG_EN
        if (hist.size() == 0) begin
            for (int i = 0; i < 4; i++) hist.push_back(d);
        end else begin
            hist.push_back(d);
            void'(hist.pop_front());
        end
        s = 0;
        foreach (hist[i]) s += hist[i];
        d = s / 4;
`else
        s = 0;
`endif
    endtask

    task automatic run_meas(input int len, input int exp_d, input int exp_t, input string tag);
        int n, hi, seen, trig_echo, gd, gt, md, mt;
        n = 0;
        while (trig !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (trig !== 1'b1) begin
            fail({tag, "_trig_rise"});
            return;
        end
        hi = 0;
        while (trig === 1'b1 && hi < 50) begin
            @(negedge clk);
            hi++;
        end
        chk({tag, "_trig_width"}, hi, TRG);
        seen = 0;
        trig_echo = 0;
        gd = -1;
        gt = -1;
        for (int i = 0; i < len; i++) begin
            echo = 1'b1;
            @(negedge clk);
            if (dist_valid) begin
                seen++;
                gd = distance;
                gt = timeout_err;
            end
            if (trig) trig_echo++;
        end
        echo = 1'b0;
        n = 0;
        while (seen == 0 && n < 400) begin
            @(negedge clk);
            n++;
            if (dist_valid) begin
                seen = 1;
                gd = distance;
                gt = timeout_err;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    if (dist_valid) seen++;
                end
            end
        end
        expect_for(len, md, mt);
        if (exp_d >= 0) begin
            md = exp_d;
            mt = exp_t;
        end
        if (seen == 0) begin
            fail({tag, "_valid"});
            return;
        end
        chk({tag, "_valid_count"}, seen, 1);
        chk({tag, "_trig_during_echo"}, trig_echo, 0);
        chk({tag, "_distance"}, gd, md);
        chk({tag, "_timeout_err"}, gt, mt);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        echo  = 1'b0;
        repeat (3) @(negedge clk);
        hist.delete();
        reset = 1'b0;
    endtask

    initial begin
        int nlow, nval, len;
        vecs[0] = '{40, 10, 0};
        vecs[1] = '{41, 10, 0};
        vecs[2] = '{3, 0, 0};
        vecs[3] = '{0, MAXMM, 1};
        vecs[4] = '{40, 10, 0};
        vecs[5] = '{4, 1, 0};
        vecs[6] = '{400, MAXMM, 0};
        vecs[7] = '{199, 49, 0};
        vecs[8] = '{200, MAXMM, 0};

        reset = 1'b1;
        echo  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_trig", trig, 0);
        chk("reset_distance", distance, 0);
        chk("reset_valid", dist_valid, 0);
        chk("reset_timeout", timeout_err, 0);
        reset = 1'b0;
        nlow = 0;
        nval = 0;
        for (int i = 0; i < HOLD; i++) begin
            @(negedge clk);
            if (!trig) nlow++;
            if (dist_valid || distance != 0) nval++;
        end
        chk("holdoff_trig_low", nlow, HOLD);
        chk("holdoff_no_valid", nval, 0);

        for (int i = 0; i < 9; i++) begin
`ifdef SONAR_DIST_AVG_EN
            run_meas(vecs[i].len, -1, 0, $sformatf("vec%0d", i));
`else
            run_meas(vecs[i].len, vecs[i].exp_d, vecs[i].exp_t, $sformatf("vec%0d", i));
`endif
        end

        for (int i = 0; i < 8; i++) begin
            len = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 260));
            run_meas(len, -1, 0, $sformatf("rnd%0d_len%0d", i, len));
        end

        nval = 0;
        while (trig !== 1'b1 && nval < 5000) begin
            @(negedge clk);
            nval++;
        end
        while (trig === 1'b1 && nval < 5000) begin
            @(negedge clk);
            nval++;
        end
        for (int i = 0; i < 20; i++) begin
            echo = 1'b1;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_trig", trig, 0);
        chk("midreset_distance", distance, 0);
        chk("midreset_valid", dist_valid, 0);
        echo = 1'b0;
        @(negedge clk);
        hist.delete();
        reset = 1'b0;
        nval = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (dist_valid) nval++;
        end
        chk("midreset_no_valid", nval, 0);
        chk("midreset_distance_held", distance, 0);
        run_meas(40, -1, 0, "post_reset");

`ifdef SONAR_DIST_AVG_EN
        do_reset();
        run_meas(40, 10, 0, "avg0");
        run_meas(80, 12, 0, "avg1");
        run_meas(80, 15, 0, "avg2");
        run_meas(80, 17, 0, "avg3");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
